bin_to_bcd_seq: RTL

- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.
- Sits directly upstream of the BCD-to-Excess-3 code converter stage.
- Each 4-bit digit of its registered BCD result feeds one Excess-3 converter instance.
- Start/busy/done handshake; the result holds stable between conversions.

---
 rtl/bcd_pkg.sv | 19 +
 rtl/bcd_digit_adj.sv | 17 +
 rtl/bin_to_bcd_seq.sv | 112 +++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the binary-to-BCD converter and the downstream
// BCD-to-Excess-3 stage.
//   bcd_state_e     : converter FSM state encoding
//   BCD_DIGIT_W     : width of one BCD digit (also used by the Excess-3 stage)
//   BCD_ADJ_THRESH  : digit value at and above which the +3 correction applies
//   BCD_ADJ_ADD     : correction added before each shift
package bcd_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } bcd_state_e;

  localparam int BCD_DIGIT_W = 4;

  localparam logic [BCD_DIGIT_W-1:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [BCD_DIGIT_W-1:0] BCD_ADJ_ADD    = 4'd3;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more so the
// following left shift carries correctly into the next digit.
//   digit    : scratch BCD digit before the shift
//   adjusted : corrected digit (4-bit wrap, no carry to the neighbour)
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BCD_DIGIT_W-1:0] adjusted
);

  always_comb begin
    if (digit >= BCD_ADJ_THRESH) adjusted = digit + BCD_ADJ_ADD;
    else                         adjusted = digit;
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per clock.
// A conversion takes BIN_W clocks from the accepting edge; bcd/ovf update only
// on completion and hold otherwise.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   start : conversion request, sampled only while idle
//   bin   : binary value, captured on the accepting edge
//   bcd   : packed BCD result, digit 0 in [3:0]
//   busy  : conversion in progress
//   done  : one-cycle pulse when bcd/ovf were just updated
//   ovf   : captured value did not fit in DIGITS decimal digits
//
// state    | meaning
// ST_IDLE  | waiting for start; result registers hold
// ST_SHIFT | adjusting and shifting one binary bit per clock
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [BIN_W-1:0]              bin,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
  output logic                          busy,
  output logic                          done,
  output logic                          ovf
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  bcd_state_e       state_q, state_d;
  logic [BIN_W-1:0] bin_q;
  logic [BCD_W-1:0] scratch_q, scratch_adj, scratch_shift;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_latch_q;
  logic [BCD_W-1:0] bcd_q;
  logic             ovf_q, done_q;
  logic             last_shift;
  logic             carry_out;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit    (scratch_q  [g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .adjusted (scratch_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Binary MSB enters digit 0; the top digit's MSB falls off and flags overflow.
  assign scratch_shift = {scratch_adj[BCD_W-2:0], bin_q[BIN_W-1]};
  assign carry_out     = scratch_adj[BCD_W-1];
  assign last_shift    = (cnt_q == CNT_W'(BIN_W - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start)      state_d = ST_SHIFT;
      ST_SHIFT: if (last_shift) state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q       <= '0;
      scratch_q   <= '0;
      cnt_q       <= '0;
      ovf_latch_q <= 1'b0;
      bcd_q       <= '0;
      ovf_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            bin_q       <= bin;
            scratch_q   <= '0;
            cnt_q       <= '0;
            ovf_latch_q <= 1'b0;
          end
        end
        ST_SHIFT: begin
          scratch_q   <= scratch_shift;
          bin_q       <= bin_q << 1;
          cnt_q       <= cnt_q + CNT_W'(1);
          ovf_latch_q <= ovf_latch_q | carry_out;
          if (last_shift) begin
            bcd_q  <= scratch_shift;
            ovf_q  <= ovf_latch_q | carry_out;
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q == ST_SHIFT);
  assign bcd  = bcd_q;
  assign done = done_q;
  assign ovf  = ovf_q;

endmodule
